datapath_mc: RTL and testbench
==============================

DATAPATH_MC -- requirements
Module: datapath_mc

Parameters
REQ-001 SHALL have parameter WORD_SIZE, default 32, meaning the data word width in bits (>=8).
REQ-002 SHALL have parameter NUM_REGS, default 4, meaning the register count (a power of two, >=4); ADDR_W = $clog2(NUM_REGS).

Interface
REQ-003 SHALL have port Clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port Rst, input, 1 bit: reset; synchronous, active-high.
REQ-005 SHALL have port InstrValid, input, 1 bit: instruction fields valid.
REQ-006 SHALL have port InstrReady, output, 1 bit: the block accepts an instruction this cycle.
REQ-007 SHALL have ports RegReadAddr1 and RegReadAddr2, input, ADDR_W bits each: source register A and source register B.
REQ-008 SHALL have port RegWriteAddr, input, ADDR_W bits: destination register.
REQ-009 SHALL have port RegWriteEnable, input, 1 bit: write the result back to the destination.
REQ-010 SHALL have port ALUControl, input, 3 bits: operation select.
REQ-011 SHALL have port Result, output, WORD_SIZE bits: registered ALU result of the last instruction.
REQ-012 SHALL have port Flags, output, 4 bits: registered {Negative, Zero, Carry, Overflow}.
REQ-013 SHALL have port Done, output, 1 bit: one-cycle pulse at instruction completion.
REQ-014 SHALL have port IllegalOp, output, 1 bit: one-cycle pulse, concurrent with Done, for an unsupported opcode.
REQ-015 SHALL have ports DbgAddr (input, ADDR_W bits) and DbgData (output, WORD_SIZE bits): combinational register-file read port.

Function
REQ-016 SHALL implement a four-state FSM: IDLE, READ, EXEC, WRITE.
REQ-017 SHALL hold InstrReady high only in IDLE; a handshake is InstrValid && InstrReady.
REQ-018 SHALL, on a handshake, latch all instruction fields and go to READ; InstrValid outside IDLE is ignored.
REQ-019 SHALL, in READ, latch operands A and B from the register file and go to EXEC.
REQ-020 SHALL, in EXEC, register Result and Flags and go to WRITE.
REQ-021 SHALL, in WRITE, write Result to the destination if RegWriteEnable was latched and the op is legal, pulse Done, and return to IDLE.
REQ-022 SHALL complete an instruction in 4 cycles: handshake at edge k, Done high in the cycle after edge k+3, next handshake possible at edge k+4.
REQ-023 SHALL decode ALUControl as follows: 000 ADD, 001 SUB (A-B), 010 AND, 011 XOR, 100 OR, 101 MUL, 110 SLT (signed, result 1 or 0), 111 PASSA.
REQ-024 SHALL wrap arithmetic modulo 2^WORD_SIZE.
REQ-025 SHALL compute Carry as the carry-out of A+B for ADD and of A+~B+1 for SUB, and as 0 for all other ops.
REQ-026 SHALL compute Overflow as signed overflow for ADD and SUB, and as 0 otherwise.
REQ-027 SHALL compute Zero as (Result==0) and Negative as Result MSB, for all ops.
REQ-028 SHALL read the value as of READ when a source equals the destination; the new value is visible to the next instruction.
REQ-029 SHALL show a completed write on DbgData in the cycle after WRITE.

Reset
REQ-030 SHALL, on Rst, set state to IDLE and clear Result, Flags, Done and IllegalOp.
REQ-031 SHALL, on Rst, set all registers to 0 except R[NUM_REGS-2] = all ones (-1) and R[NUM_REGS-1] = 1.
REQ-032 SHALL, on Rst during READ, EXEC or WRITE, abort the instruction with no register write and no Done pulse; Rst has priority over every other event.

Configuration
REQ-033 SHALL compile in MUL (low WORD_SIZE bits of A*B, Carry and Overflow = 0) when DATAPATH_MUL_EN is defined.
REQ-034 SHALL, when DATAPATH_MUL_EN is undefined, treat opcode 101 as illegal: Result 0, Flags unchanged, no write, IllegalOp pulsed with Done.

Structure
REQ-035 SHALL place the ALU opcode localparams, the FSM state enum and the flag bit indices in the shared package datapath_pkg.
REQ-036 SHALL implement the ALU as a combinational sub-module alu (WORD_SIZE parameter; outputs result and flags); the FSM and register file stay in datapath_mc.

Verification (WORD_SIZE=32, NUM_REGS=4)
REQ-037 SHALL check: Rst for 1 cycle -> DbgData shows R0=0, R1=0, R2=FFFFFFFF, R3=1; InstrReady=1.
REQ-038 SHALL check the sequence R1<-R0^R0, R0<-R2+R1, R2<-R1-R3, R3<-R0+R3 -> R0=FFFFFFFF, R1=0, R2=FFFFFFFF, R3=0; each Done exactly 3 cycles after its handshake edge.
REQ-039 SHALL check: with R0=7FFFFFFF and R3=1, ADD -> Result 80000000, Flags N=1, Z=0, C=0, V=1; SUB R3-R3 -> Z=1, C=1.
REQ-040 SHALL check: InstrValid held high for 8 cycles -> exactly 2 instructions accepted; InstrReady low in READ, EXEC and WRITE.
REQ-041 SHALL check: Rst asserted in EXEC of a write to R1 -> R1 unchanged, no Done, IDLE on the next cycle.
REQ-042 SHALL check opcode 101 on R2,R2: with DATAPATH_MUL_EN -> Result 1; without it -> IllegalOp=1 and the destination unchanged.

Source files
------------

// File: rtl/datapath_pkg.sv
// Shared definitions for the multi-cycle datapath: ALU opcodes, FSM states, flag bit positions.
package datapath_pkg;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_AND   = 3'b010;
  localparam logic [2:0] ALU_XOR   = 3'b011;
  localparam logic [2:0] ALU_OR    = 3'b100;
  localparam logic [2:0] ALU_MUL   = 3'b101;
  localparam logic [2:0] ALU_SLT   = 3'b110;
  localparam logic [2:0] ALU_PASSA = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_EXEC  = 2'd2,
    ST_WRITE = 2'd3
  } state_t;

  // Bit positions inside the 4-bit {Negative, Zero, Carry, Overflow} flag word.
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/alu.sv
// Combinational ALU for datapath_mc. MUL is built only when DATAPATH_MUL_EN is defined;
// otherwise opcode 101 reports o_illegal with a zero result.
module alu
  import datapath_pkg::*;
#(
  parameter int WORD_SIZE = 32
) (
  input  logic [WORD_SIZE-1:0] i_a,
  input  logic [WORD_SIZE-1:0] i_b,
  input  logic [2:0]           i_op,
  output logic [WORD_SIZE-1:0] o_result,
  output logic [3:0]           o_flags,
  output logic                 o_illegal
);

  logic [WORD_SIZE:0]   w_sum;
  logic [WORD_SIZE:0]   w_diff;
  logic                 w_slt;
  logic                 w_carry;
  logic                 w_ovf;
`ifdef DATAPATH_MUL_EN
  logic [WORD_SIZE-1:0] w_prod;
  assign w_prod = i_a * i_b;
`endif

  // Subtraction as A + ~B + 1 so the carry-out means "no borrow".
  assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
  assign w_diff = {1'b0, i_a} + {1'b0, ~i_b} + {{WORD_SIZE{1'b0}}, 1'b1};
  assign w_slt  = $signed(i_a) < $signed(i_b);

  always_comb begin
    o_result  = '0;
    w_carry   = 1'b0;
    w_ovf     = 1'b0;
    o_illegal = 1'b0;
    case (i_op)
      ALU_ADD: begin
        o_result = w_sum[WORD_SIZE-1:0];
        w_carry  = w_sum[WORD_SIZE];
        w_ovf    = (i_a[WORD_SIZE-1] == i_b[WORD_SIZE-1]) &&
                   (w_sum[WORD_SIZE-1] != i_a[WORD_SIZE-1]);
      end
      ALU_SUB: begin
        o_result = w_diff[WORD_SIZE-1:0];
        w_carry  = w_diff[WORD_SIZE];
        w_ovf    = (i_a[WORD_SIZE-1] != i_b[WORD_SIZE-1]) &&
                   (w_diff[WORD_SIZE-1] != i_a[WORD_SIZE-1]);
      end
      ALU_AND:   o_result = i_a & i_b;
      ALU_XOR:   o_result = i_a ^ i_b;
      ALU_OR:    o_result = i_a | i_b;
`ifdef DATAPATH_MUL_EN
      ALU_MUL:   o_result = w_prod;
`else
      ALU_MUL:   o_illegal = 1'b1;
`endif
      ALU_SLT:   o_result = {{(WORD_SIZE-1){1'b0}}, w_slt};
      ALU_PASSA: o_result = i_a;
      default:   o_result = '0;
    endcase
  end

  always_comb begin
    o_flags         = '0;
    o_flags[FLAG_N] = o_result[WORD_SIZE-1];
    o_flags[FLAG_Z] = (o_result == '0);
    o_flags[FLAG_C] = w_carry;
    o_flags[FLAG_V] = w_ovf;
  end

endmodule

// File: rtl/datapath_mc.sv
// Multi-cycle datapath: IDLE/READ/EXEC/WRITE sequencer, register file and ALU (alu.sv).
// Optional MUL opcode controlled by DATAPATH_MUL_EN.
module datapath_mc
  import datapath_pkg::*;
#(
  parameter  int WORD_SIZE = 32,
  parameter  int NUM_REGS  = 4,
  localparam int ADDR_W    = $clog2(NUM_REGS)
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 InstrValid,
  output logic                 InstrReady,
  input  logic [ADDR_W-1:0]    RegReadAddr1,
  input  logic [ADDR_W-1:0]    RegReadAddr2,
  input  logic [ADDR_W-1:0]    RegWriteAddr,
  input  logic                 RegWriteEnable,
  input  logic [2:0]           ALUControl,
  output logic [WORD_SIZE-1:0] Result,
  output logic [3:0]           Flags,
  output logic                 Done,
  output logic                 IllegalOp,
  input  logic [ADDR_W-1:0]    DbgAddr,
  output logic [WORD_SIZE-1:0] DbgData,
  output logic [1:0]           DbgState
);

  // Handshake: an instruction is taken on a rising edge where InstrValid && InstrReady.
  // InstrReady is high only in IDLE; InstrValid is ignored in every other state.

  localparam logic [WORD_SIZE-1:0] REG_ONE = {{(WORD_SIZE-1){1'b0}}, 1'b1};

  state_t               r_state;
  state_t               w_next;
  logic                 w_accept;
  logic                 w_read;
  logic                 w_exec;
  logic                 w_write;

  logic [WORD_SIZE-1:0] r_regs [NUM_REGS];
  logic [ADDR_W-1:0]    r_ra1;
  logic [ADDR_W-1:0]    r_ra2;
  logic [ADDR_W-1:0]    r_wa;
  logic                 r_we;
  logic [2:0]           r_op;
  logic [WORD_SIZE-1:0] r_a;
  logic [WORD_SIZE-1:0] r_b;
  logic [WORD_SIZE-1:0] r_result;
  logic [3:0]           r_flags;
  logic                 r_done;
  logic                 r_illegal;

  logic [WORD_SIZE-1:0] w_alu_result;
  logic [3:0]           w_alu_flags;
  logic                 w_alu_illegal;

  alu #(.WORD_SIZE(WORD_SIZE)) u_alu (
    .i_a      (r_a),
    .i_b      (r_b),
    .i_op     (r_op),
    .o_result (w_alu_result),
    .o_flags  (w_alu_flags),
    .o_illegal(w_alu_illegal)
  );

  always_ff @(posedge Clk) begin
    if (Rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    InstrReady = 1'b0;
    w_accept   = 1'b0;
    w_read     = 1'b0;
    w_exec     = 1'b0;
    w_write    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        InstrReady = 1'b1;
        if (InstrValid) begin
          w_accept = 1'b1;
          w_next   = ST_READ;
        end
      end
      ST_READ: begin
        w_read = 1'b1;
        w_next = ST_EXEC;
      end
      ST_EXEC: begin
        w_exec = 1'b1;
        w_next = ST_WRITE;
      end
      ST_WRITE: begin
        w_write = 1'b1;
        w_next  = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_result  <= '0;
      r_flags   <= '0;
      r_done    <= 1'b0;
      r_illegal <= 1'b0;
      r_ra1     <= '0;
      r_ra2     <= '0;
      r_wa      <= '0;
      r_we      <= 1'b0;
      r_op      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (i == NUM_REGS - 1)      r_regs[i] <= REG_ONE;
        else if (i == NUM_REGS - 2) r_regs[i] <= '1;
        else                        r_regs[i] <= '0;
      end
    end else begin
      r_done    <= w_write;
      r_illegal <= w_write && w_alu_illegal;
      if (w_accept) begin
        r_ra1 <= RegReadAddr1;
        r_ra2 <= RegReadAddr2;
        r_wa  <= RegWriteAddr;
        r_we  <= RegWriteEnable;
        r_op  <= ALUControl;
      end
      // Operands are captured here, so a source equal to the destination sees the old value.
      if (w_read) begin
        r_a <= r_regs[r_ra1];
        r_b <= r_regs[r_ra2];
      end
      if (w_exec) begin
        r_result <= w_alu_result;
        if (!w_alu_illegal) r_flags <= w_alu_flags;
      end
      if (w_write && r_we && !w_alu_illegal) r_regs[r_wa] <= r_result;
    end
  end

  assign Result    = r_result;
  assign Flags     = r_flags;
  assign Done      = r_done;
  assign IllegalOp = r_illegal;
  assign DbgData   = r_regs[DbgAddr];
  assign DbgState  = r_state;

endmodule

// File: tb/tb_datapath_mc.sv
// Scoreboard bench for datapath_mc (WORD_SIZE=32, NUM_REGS=4) with an arithmetic reference model.
module tb_datapath_mc;

  localparam int W  = 32;
  localparam int NR = 4;
  localparam int AW = 2;

  logic          Clk = 1'b0;
  logic          Rst = 1'b1;
  logic          InstrValid = 1'b0;
  logic          InstrReady;
  logic [AW-1:0] RegReadAddr1 = '0;
  logic [AW-1:0] RegReadAddr2 = '0;
  logic [AW-1:0] RegWriteAddr = '0;
  logic          RegWriteEnable = 1'b0;
  logic [2:0]    ALUControl = '0;
  logic [W-1:0]  Result;
  logic [3:0]    Flags;
  logic          Done;
  logic          IllegalOp;
  logic [AW-1:0] DbgAddr = '0;
  logic [W-1:0]  DbgData;
  logic [1:0]    DbgState;

  datapath_mc #(.WORD_SIZE(W), .NUM_REGS(NR)) dut (
    .Clk(Clk), .Rst(Rst), .InstrValid(InstrValid), .InstrReady(InstrReady),
    .RegReadAddr1(RegReadAddr1), .RegReadAddr2(RegReadAddr2),
    .RegWriteAddr(RegWriteAddr), .RegWriteEnable(RegWriteEnable),
    .ALUControl(ALUControl), .Result(Result), .Flags(Flags), .Done(Done),
    .IllegalOp(IllegalOp), .DbgAddr(DbgAddr), .DbgData(DbgData), .DbgState(DbgState)
  );

  // ---------------- clock / cycle counter / watchdog ----------------
  always #5 Clk = ~Clk;

  int unsigned cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required finish before 100000");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  int          cmp_cnt  = 0;
  int          fail_cnt = 0;
  int          done_cnt = 0;
  logic        last_ill = 1'b0;
  logic [36:0] exp_q[$];
  int unsigned hs_q[$];
  logic [W-1:0] m_regs[NR];
  logic [3:0]   m_flags;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on 64-bit values.
  function automatic void model_exec(input logic [2:0] op, input logic [W-1:0] a,
                                     input logic [W-1:0] b, output logic [W-1:0] res,
                                     output logic [3:0] fl, output logic ill);
    longint          sa = longint'($signed(a));
    longint          sb = longint'($signed(b));
    longint unsigned ua = 64'(a);
    longint unsigned ub = 64'(b);
    longint          s;
    logic            c = 1'b0;
    logic            v = 1'b0;
    ill = 1'b0;
    res = '0;
    case (op)
      3'd0: begin
        res = 32'(ua + ub);
        c   = (ua + ub) > 64'hFFFF_FFFF;
        s   = sa + sb;
        v   = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      3'd1: begin
        res = 32'(ua - ub);
        c   = ua >= ub;
        s   = sa - sb;
        v   = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      3'd2: res = a & b;
      3'd3: res = a ^ b;
      3'd4: res = a | b;
`ifdef DATAPATH_MUL_EN
      3'd5: res = 32'(ua * ub);
`else
      3'd5: ill = 1'b1;
`endif
      3'd6: res = (sa < sb) ? 32'd1 : 32'd0;
      default: res = a;
    endcase
    fl = ill ? m_flags : {res[W-1], res == '0, c, v};
  endfunction

  // Called at the negedge before the handshake edge.
  task automatic push_expect(input logic [2:0] op, input int ra1, input int ra2,
                             input int wa, input logic we);
    logic [W-1:0] res;
    logic [3:0]   fl;
    logic         ill;
    model_exec(op, m_regs[ra1], m_regs[ra2], res, fl, ill);
    exp_q.push_back({ill, fl, res});
    hs_q.push_back(cyc + 1);
    m_flags = fl;
    if (we && !ill) m_regs[wa] = res;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NR; i++) m_regs[i] = '0;
    m_regs[NR-2] = '1;
    m_regs[NR-1] = 32'd1;
    m_flags = '0;
  endtask

  // ---------------- monitor ----------------
  logic [36:0] mon_e;
  int unsigned mon_hs;
  always @(negedge Clk) begin
    if (Done) begin
      done_cnt++;
      last_ill = IllegalOp;
      if (exp_q.size() == 0) begin
        cmp_cnt++;
        fail_cnt++;
        $display("FAIL unexpected_done: got Done=1 at cycle %0d, required no completion", cyc);
      end else begin
        mon_e  = exp_q.pop_front();
        mon_hs = hs_q.pop_front();
        check("result",  64'(Result),    64'(mon_e[31:0]));
        check("flags",   64'(Flags),     64'(mon_e[35:32]));
        check("illegal", 64'(IllegalOp), 64'(mon_e[36]));
        check("latency", 64'(cyc - mon_hs), 64'd3);
      end
    end else if (IllegalOp) begin
      cmp_cnt++;
      fail_cnt++;
      $display("FAIL illegal_without_done: got IllegalOp=1 Done=0, required Done with IllegalOp");
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge Clk);
    Rst = 1'b1;
    InstrValid = 1'b0;
    @(posedge Clk);
    @(negedge Clk);
    Rst = 1'b0;
    model_reset();
    check("rst_result", 64'(Result), 64'd0);
    check("rst_flags",  64'(Flags),  64'd0);
    check("rst_done",   64'(Done),   64'd0);
    check("rst_ready",  64'(InstrReady), 64'd1);
  endtask

  task automatic issue(input logic [2:0] op, input int ra1, input int ra2,
                       input int wa, input logic we);
    int n;
    @(negedge Clk);
    InstrValid     = 1'b1;
    ALUControl     = op;
    RegReadAddr1   = AW'(ra1);
    RegReadAddr2   = AW'(ra2);
    RegWriteAddr   = AW'(wa);
    RegWriteEnable = we;
    n = 0;
    while (!InstrReady && n < 20) begin
      @(negedge Clk);
      n++;
    end
    if (!InstrReady) begin
      cmp_cnt++;
      fail_cnt++;
      $display("FAIL handshake_timeout: got InstrReady=0 for 20 cycles, required 1");
    end else begin
      push_expect(op, ra1, ra2, wa, we);
    end
    @(posedge Clk);
    #1 InstrValid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge Clk);
      #1 n++;
    end
    check("drain_pending", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < NR; i++) begin
      DbgAddr = AW'(i);
      #1 check($sformatf("%s_r%0d", tag, i), 64'(DbgData), 64'(m_regs[i]));
    end
  endtask

  // ---------------- stimulus ----------------
  int accepted;
  int bad_ready;
  int d0;

  initial begin
    model_reset();
    repeat (2) @(posedge Clk);
    do_reset();

    // Reset contents
    DbgAddr = 2'd0; #1 check("init_r0", 64'(DbgData), 64'h0);
    DbgAddr = 2'd1; #1 check("init_r1", 64'(DbgData), 64'h0);
    DbgAddr = 2'd2; #1 check("init_r2", 64'(DbgData), 64'hFFFF_FFFF);
    DbgAddr = 2'd3; #1 check("init_r3", 64'(DbgData), 64'h1);
    check("init_state", 64'(DbgState), 64'd0);

    // Dependent sequence
    issue(3'b011, 0, 0, 1, 1'b1);
    issue(3'b000, 2, 1, 0, 1'b1);
    issue(3'b001, 1, 3, 2, 1'b1);
    issue(3'b000, 0, 3, 3, 1'b1);
    drain();
    check_regs("seq");
    DbgAddr = 2'd0; #1 check("seq_r0_const", 64'(DbgData), 64'hFFFF_FFFF);
    DbgAddr = 2'd3; #1 check("seq_r3_const", 64'(DbgData), 64'h0);

    // Signed overflow on ADD; SUB of equal operands
    do_reset();
    issue(3'b000, 3, 3, 0, 1'b1);
    repeat (30) issue(3'b000, 0, 0, 0, 1'b1);
    issue(3'b001, 0, 3, 0, 1'b1);
    issue(3'b000, 0, 3, 1, 1'b0);
    drain();
    check("ovf_result", 64'(Result), 64'h8000_0000);
    check("ovf_flags",  64'(Flags),  64'b1001);
    issue(3'b001, 3, 3, 1, 1'b0);
    drain();
    check("sub_zero_flags", 64'(Flags), 64'b0110);
    check_regs("ovf");

    // InstrValid held high for 8 cycles
    do_reset();
    @(negedge Clk);
    ALUControl = 3'b000; RegReadAddr1 = 2'd1; RegReadAddr2 = 2'd3;
    RegWriteAddr = 2'd1; RegWriteEnable = 1'b1; InstrValid = 1'b1;
    accepted = 0;
    bad_ready = 0;
    for (int i = 0; i < 8; i++) begin
      if (InstrReady != (DbgState == 2'd0)) bad_ready++;
      if (InstrReady) begin
        accepted++;
        push_expect(3'b000, 1, 3, 1, 1'b1);
      end
      @(negedge Clk);
    end
    InstrValid = 1'b0;
    check("hold_accepted", 64'(accepted), 64'd2);
    check("hold_ready_bad", 64'(bad_ready), 64'd0);
    drain();
    check_regs("hold");

    // Reset in EXEC aborts a write to R1
    do_reset();
    @(negedge Clk);
    ALUControl = 3'b111; RegReadAddr1 = 2'd2; RegReadAddr2 = 2'd0;
    RegWriteAddr = 2'd1; RegWriteEnable = 1'b1; InstrValid = 1'b1;
    @(posedge Clk);
    #1 InstrValid = 1'b0;
    @(posedge Clk);
    @(negedge Clk);
    check("abort_in_exec", 64'(DbgState), 64'd2);
    d0 = done_cnt;
    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    model_reset();
    check("abort_state", 64'(DbgState), 64'd0);
    check("abort_ready", 64'(InstrReady), 64'd1);
    repeat (5) @(negedge Clk);
    check("abort_no_done", 64'(done_cnt - d0), 64'd0);
    check_regs("abort");

    // Opcode 101 on R2,R2 after a flag-setting SUB
    issue(3'b001, 3, 3, 0, 1'b0);
    issue(3'b101, 2, 2, 1, 1'b1);
    drain();
`ifdef DATAPATH_MUL_EN
    check("mul_result", 64'(Result), 64'd1);
    check("mul_illegal", 64'(last_ill), 64'd0);
`else
    check("illegal_pulse", 64'(last_ill), 64'd1);
    check("illegal_result", 64'(Result), 64'd0);
    check("illegal_flags", 64'(Flags), 64'b0110);
`endif
    check_regs("op101");

    // Random instructions
    repeat (40) begin
      issue(3'($urandom_range(0, 7)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
            int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end
    drain();
    check_regs("rand");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
    $finish;
  end

endmodule
